multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Moore FSM sequencing a multi-cycle MIPS datapath (shared memory, IR, MDR, one ALU) for R-type add/and/or, lw, sw, addi, andi.
//  Replaces per-instruction combinational control with per-state strobes.
//  Adds a memory request/ready handshake and a bounded-wait timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles waiting on mem_ready before abort (>=1)
//  CNT_W           8    width of wait counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  instr          in   32  IR contents (opcode [31:26], funct [5:0]); valid from DECODE on
//  mem_ready      in   1   memory completes current mem_req this cycle
//  mem_req        out  1   memory access request; held until mem_ready or timeout
//  mem_we         out  1   write qualifier for mem_req
//  iord           out  1   address source: 0=PC, 1=ALUOut
//  ir_write       out  1   load IR
//  mdr_write      out  1   load MDR
//  pc_write       out  1   unconditional PC load
//  pc_write_cond  out  1   PC load if ALU zero (branch)
//  pc_src         out  2   00=ALU result, 01=ALUOut, 10=jump target
//  alu_src_a      out  1   0=PC, 1=rs
//  alu_src_b      out  2   00=rt, 01=const 4, 10=sign-ext imm, 11=zero-ext imm
//  alu_ctrl       out  3   000=and, 001=or, 010=add, 110=sub
//  reg_write      out  1   register file write enable
//  reg_dst        out  1   0=rt, 1=rd
//  mem_to_reg     out  1   0=ALUOut, 1=MDR
//  illegal        out  1   1-cycle pulse in DECODE on unsupported opcode/funct
//  mem_timeout    out  1   1-cycle pulse when a memory wait aborts
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=S_RESET, wait counter=0, all outputs 0. S_RESET -> S_FETCH on the next clock.
//  - Outputs are decoded from the state register and instr only; mem_ready gates the strobes marked (*). Next state is registered.
//  - States and transitions:
//   FETCH:  mem_req, iord=0, src_a=0, src_b=01, alu=add, pc_src=00; ir_write(*), pc_write(*). mem_ready -> DECODE.
//   DECODE: classify opcode: R-type -> EXEC; lw/sw -> MEMADR; addi/andi -> IEXEC; other -> FETCH with illegal.
//           An R-type funct not in {100000,100100,100101} also takes FETCH with illegal.
//   MEMADR: src_a=1, src_b=10, alu=add. lw -> MEMRD, sw -> MEMWR.
//   MEMRD:  mem_req, iord=1; mdr_write(*). mem_ready -> MEMWB.
//   MEMWB:  reg_write, reg_dst=0, mem_to_reg=1 -> FETCH.
//   MEMWR:  mem_req, mem_we, iord=1. mem_ready -> FETCH.
//   EXEC:   src_a=1, src_b=00, alu from funct (add=010, and=000, or=001) -> RWB.
//   RWB:    reg_write, reg_dst=1, mem_to_reg=0 -> FETCH.
//   IEXEC:  src_a=1; addi: src_b=10, alu=add; andi: src_b=11, alu=and -> IWB.
//   IWB:    reg_write, reg_dst=0, mem_to_reg=0 -> FETCH.
//  - Cycle counts with zero-wait memory: lw=5, sw=4, R/addi/andi=4, illegal=2.
//  - Wait counter: clears on entry to every mem state and increments each cycle of mem_req without mem_ready.
//    On the cycle it equals TIMEOUT_CYCLES-1 without mem_ready, mem_timeout pulses and the FSM goes to FETCH.
//    A FETCH timeout does not assert ir_write/pc_write, so the same PC is refetched.
//    mem_ready on the final cycle wins over the timeout.
//  - mem_req deasserts on the cycle after mem_ready. Back-to-back FETCHes (illegal path) re-raise it after one idle cycle.
//  - Reset mid-access drops mem_req immediately (async); no partial write is retried.
// CONFIGURATION
//  MULTICYCLE_BRANCH_EN defined: adds beq (000100) and j (000010).
//   - DECODE computes the target: src_a=0, src_b=10 (imm<<2 in the datapath), alu=add.
//   - beq -> BEQ: src_a=1, src_b=00, alu=sub, pc_write_cond=1, pc_src=01 -> FETCH.
//   - j -> JMP: pc_write=1, pc_src=10 -> FETCH.
//  Not defined: both opcodes are illegal, pc_write_cond is tied 0 and pc_src is never 01/10.
// STRUCTURE
//  - Package mips_ctrl_pkg: opcode/funct localparams, ALU_* encodings, SRCB_* encodings and the state encoding (4-bit).
//  - Sub-module mips_alu_decoder: combinational funct -> {alu_ctrl, valid}, shared with EXEC and DECODE legality check.
// TESTING
//  1. Reset with rst_n low, release -> all outputs 0 in S_RESET; mem_req=1, iord=0 on the next cycle.
//  2. add $3,$1,$2 (0x00221820), zero-wait memory -> 4 cycles; RWB has reg_write=1, reg_dst=1; EXEC alu_ctrl=010.
//  3. lw (0x8C220004) with mem_ready held low 3 cycles in MEMRD -> mdr_write only on the ready cycle; 8 cycles total.
//  4. sw (0xAC220008) with mem_ready never asserted, TIMEOUT_CYCLES=4 -> mem_timeout after 4 MEMWR cycles, then FETCH.
//  5. andi (0x3022FFFF) -> IEXEC src_b=11, alu=000. Opcode 0x3F -> illegal pulse, back in FETCH 2 cycles after fetch.
//  6. With MULTICYCLE_BRANCH_EN, beq (0x10220003) -> BEQ pc_write_cond=1, pc_src=01. Without it -> illegal=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Purpose: shared encodings for the multi-cycle MIPS control path (opcodes, functs, ALU/mux selects, FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro used by importers: MULTICYCLE_BRANCH_EN (beq/j support).
package mips_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

    // ALU operation select
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;
    localparam logic [1:0] SRCB_ZEXT = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_BEQ    = 4'd11,
        S_JMP    = 4'd12
    } state_t;

    // States that hold a memory request open.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Purpose: map an R-type funct to an ALU operation and flag whether the funct is supported.
// Latency: purely combinational.
// Backpressure: none.
// Ports: funct[5:0] in; alu_ctrl[2:0] out (ALU_* encoding); valid out (1 = add/and/or).
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       valid
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        valid    = 1'b0;
        case (funct)
            FUNCT_ADD: begin alu_ctrl = ALU_ADD; valid = 1'b1; end
            FUNCT_AND: begin alu_ctrl = ALU_AND; valid = 1'b1; end
            FUNCT_OR:  begin alu_ctrl = ALU_OR;  valid = 1'b1; end
            default:   begin alu_ctrl = ALU_ADD; valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Purpose: Moore FSM issuing per-state datapath strobes for a multi-cycle MIPS core (R add/and/or, lw, sw, addi, andi).
// Latency: zero-wait memory -> lw 5 cycles, sw/R/addi/andi 4, illegal 2; each memory wait cycle adds one.
// Backpressure: mem_req held until mem_ready; abort with mem_timeout after TIMEOUT_CYCLES unready cycles.
// Ports: clk, rst_n (async active-low); instr[31:0], mem_ready in;
//        mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_write_cond, pc_src[1:0],
//        alu_src_a, alu_src_b[1:0], alu_ctrl[2:0], reg_write, reg_dst, mem_to_reg, illegal, mem_timeout out.
// Build option: define MULTICYCLE_BRANCH_EN to add beq/j; otherwise both decode as illegal.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        mdr_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic        mem_timeout
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             at_limit;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [2:0]       funct_alu;
    logic             funct_vld;
    logic             unused_instr;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign unused_instr = ^instr[25:6];

    // Last permitted wait cycle; unready here means the access is abandoned.
    assign at_limit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    mips_alu_decoder u_alu_dec (
        .funct    (funct),
        .alu_ctrl (funct_alu),
        .valid    (funct_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Any state change (including a FETCH->FETCH timeout retry) starts the
    // next memory state with a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if ((state_d != state_q) || mem_timeout) begin
            wait_cnt_q <= '0;
        end else if (is_mem_state(state_q) && !mem_ready) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PCSRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_ctrl      = ALU_AND;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal       = 1'b0;
        mem_timeout   = 1'b0;

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_ctrl  = ALU_ADD;
                if (mem_ready) begin
                    // IR and PC+4 commit only with the data; a timeout refetches the same PC.
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (at_limit) begin
                    mem_timeout = 1'b1;
                    state_d     = S_FETCH;
                end
            end

            S_DECODE: begin
`ifdef MULTICYCLE_BRANCH_EN
                // Speculatively form PC + (imm<<2) so BEQ can use it from ALUOut.
                alu_src_b = SRCB_SEXT;
                alu_ctrl  = ALU_ADD;
`endif
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_vld) begin
                            state_d = S_EXEC;
                        end else begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_ADDI, OP_ANDI: state_d = S_IEXEC;
`ifdef MULTICYCLE_BRANCH_EN
                    OP_BEQ:           state_d = S_BEQ;
                    OP_J:             state_d = S_JMP;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SEXT;
                alu_ctrl  = ALU_ADD;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end

            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    mdr_write = 1'b1;
                    state_d   = S_MEMWB;
                end else if (at_limit) begin
                    mem_timeout = 1'b1;
                    state_d     = S_FETCH;
                end
            end

            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (at_limit) begin
                    mem_timeout = 1'b1;
                    state_d     = S_FETCH;
                end
            end

            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                alu_ctrl  = funct_alu;
                state_d   = S_RWB;
            end

            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end

            S_IEXEC: begin
                alu_src_a = 1'b1;
                if (opcode == OP_ANDI) begin
                    alu_src_b = SRCB_ZEXT;
                    alu_ctrl  = ALU_AND;
                end else begin
                    alu_src_b = SRCB_SEXT;
                    alu_ctrl  = ALU_ADD;
                end
                state_d = S_IWB;
            end

            S_IWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end

`ifdef MULTICYCLE_BRANCH_EN
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_RT;
                alu_ctrl      = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
                state_d       = S_FETCH;
            end

            S_JMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
                state_d  = S_FETCH;
            end
`endif

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose: self-checking bench for multicycle_control; a trace model expands each instruction into its expected per-cycle strobes.
// Latency: one compare per clock, sampled 2 time units after the falling edge.
// Backpressure: memory wait schedule supplied per case; TIMEOUT_CYCLES fixed at 4.
module tb_multicycle_control;

    localparam int TMO = 4;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       mdr_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
        logic       mem_timeout;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;

    logic       mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_write_cond;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal, mem_timeout;
    logic [2:0] alu_ctrl;
    ctl_t       dut_ctl;

    int total = 0;
    int bad   = 0;

    ctl_t        exp_q[$];
    logic [31:0] ins_q[$];
    logic        rdy_q[$];

    int n_ill, n_tmo, n_mdr;

    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .mdr_write     (mdr_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_ctrl      (alu_ctrl),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .illegal       (illegal),
        .mem_timeout   (mem_timeout)
    );

    assign dut_ctl = '{mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_write_cond,
                       pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_write, reg_dst,
                       mem_to_reg, illegal, mem_timeout};

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic check_ctl(input string name, input int cyc, input ctl_t got, input ctl_t want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic push(input logic [31:0] ins, input logic rdy, input ctl_t c);
        exp_q.push_back(c);
        ins_q.push_back(ins);
        rdy_q.push_back(rdy);
    endtask

    // One memory access: kind 0 = fetch, 1 = read, 2 = write.
    // Data arrives after 'waits' unready cycles unless that exceeds the wait budget.
    task automatic mem_phase(input logic [31:0] ins, input int kind, input int waits, output bit ok);
        ctl_t c;
        ctl_t r;
        c = '0;
        c.mem_req = 1'b1;
        if (kind == 0) begin
            c.alu_src_b = 2'b01;
            c.alu_ctrl  = 3'b010;
        end else begin
            c.iord   = 1'b1;
            c.mem_we = (kind == 2);
        end
        ok = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            if (k == waits) begin
                r = c;
                if (kind == 0) begin
                    r.ir_write = 1'b1;
                    r.pc_write = 1'b1;
                end
                if (kind == 1) r.mdr_write = 1'b1;
                push(ins, 1'b1, r);
                ok = 1'b1;
                return;
            end
            if (k == TMO - 1) begin
                r = c;
                r.mem_timeout = 1'b1;
                push(ins, 1'b0, r);
                return;
            end
            push(ins, 1'b0, c);
        end
    endtask

    // Expand one instruction into its expected cycle trace.
    task automatic plan(input logic [31:0] ins, input int fw, input int mw);
        bit         ok;
        ctl_t       c;
        logic [5:0] op;
        logic [5:0] fn;
        logic [2:0] rop;
        bit         legal;
        op = ins[31:26];
        fn = ins[5:0];
        mem_phase(ins, 0, fw, ok);
        if (!ok) return;

        c = '0;
`ifdef MULTICYCLE_BRANCH_EN
        c.alu_src_b = 2'b10;
        c.alu_ctrl  = 3'b010;
`endif
        legal = 1'b1;
        rop   = 3'b010;
        case (op)
            6'h00: begin
                if (fn == 6'h20)      rop = 3'b010;
                else if (fn == 6'h24) rop = 3'b000;
                else if (fn == 6'h25) rop = 3'b001;
                else                  legal = 1'b0;
            end
            6'h23, 6'h2B, 6'h08, 6'h0C: legal = 1'b1;
`ifdef MULTICYCLE_BRANCH_EN
            6'h04, 6'h02: legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
        c.illegal = !legal;
        push(ins, 1'b0, c);
        if (!legal) return;

        c = '0;
        case (op)
            6'h00: begin
                c.alu_src_a = 1'b1; c.alu_ctrl = rop;
                push(ins, 1'b0, c);
                c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1;
                push(ins, 1'b0, c);
            end
            6'h23, 6'h2B: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = 3'b010;
                push(ins, 1'b0, c);
                mem_phase(ins, (op == 6'h23) ? 1 : 2, mw, ok);
                if (op == 6'h23 && ok) begin
                    c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                    push(ins, 1'b0, c);
                end
            end
            6'h08, 6'h0C: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = (op == 6'h0C) ? 2'b11 : 2'b10;
                c.alu_ctrl  = (op == 6'h0C) ? 3'b000 : 3'b010;
                push(ins, 1'b0, c);
                c = '0; c.reg_write = 1'b1;
                push(ins, 1'b0, c);
            end
            6'h04: begin
                c.alu_src_a = 1'b1; c.alu_ctrl = 3'b110;
                c.pc_write_cond = 1'b1; c.pc_src = 2'b01;
                push(ins, 1'b0, c);
            end
            default: begin
                c.pc_write = 1'b1; c.pc_src = 2'b10;
                push(ins, 1'b0, c);
            end
        endcase
    endtask

    // Plan, pin the trace length, replay against the DUT, then pin pulse counts.
    task automatic run_case(input string name, input logic [31:0] ins, input int fw, input int mw,
                            input int exp_len, input int exp_ill, input int exp_tmo, input int exp_mdr);
        int   cyc;
        ctl_t e;
        plan(ins, fw, mw);
        check_int({name, "_len"}, exp_q.size(), exp_len);
        n_ill = 0; n_tmo = 0; n_mdr = 0;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            instr     = ins_q.pop_front();
            mem_ready = rdy_q.pop_front();
            e         = exp_q.pop_front();
            #2;
            check_ctl(name, cyc, dut_ctl, e);
            n_ill += int'(illegal);
            n_tmo += int'(mem_timeout);
            n_mdr += int'(mdr_write);
            cyc++;
        end
        check_int({name, "_illegal_cnt"}, n_ill, exp_ill);
        check_int({name, "_timeout_cnt"}, n_tmo, exp_tmo);
        check_int({name, "_mdr_cnt"}, n_mdr, exp_mdr);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_ctl("reset_held", 0, dut_ctl, ctl_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check_ctl("s_reset", 0, dut_ctl, ctl_t'(0));

        run_case("add",        32'h00221820, 0, 0,  4, 0, 0, 0);
        run_case("lw_wait3",   32'h8C220004, 0, 3,  8, 0, 0, 1);
        run_case("sw_timeout", 32'hAC220008, 0, 99, 7, 0, 1, 0);
        run_case("andi",       32'h3022FFFF, 0, 0,  4, 0, 0, 0);
        run_case("op3f",       32'hFC000000, 0, 0,  2, 1, 0, 0);
        run_case("op3f_again", 32'hFC000000, 1, 0,  3, 1, 0, 0);
        run_case("addi_fw2",   32'h20220005, 2, 0,  6, 0, 0, 0);
        run_case("r_sub",      32'h00221822, 0, 0,  2, 1, 0, 0);
        run_case("or",         32'h00221825, 0, 0,  4, 0, 0, 0);
        run_case("and",        32'h00221824, 0, 0,  4, 0, 0, 0);
        run_case("fetch_tmo",  32'h00221820, 99, 0, 4, 0, 1, 0);
        run_case("refetch",    32'h00221820, 0, 0,  4, 0, 0, 0);
        run_case("lw_rd_tmo",  32'h8C220004, 0, 99, 7, 0, 1, 0);
        run_case("lw",         32'h8C220004, 0, 0,  5, 0, 0, 1);
        run_case("sw",         32'hAC220008, 0, 0,  4, 0, 0, 0);
`ifdef MULTICYCLE_BRANCH_EN
        run_case("beq",        32'h10220003, 0, 0,  3, 0, 0, 0);
        run_case("j",          32'h08000010, 0, 0,  3, 0, 0, 0);
`else
        run_case("beq",        32'h10220003, 0, 0,  2, 1, 0, 0);
        run_case("j",          32'h08000010, 0, 0,  2, 1, 0, 0);
`endif

        // Async reset in the middle of a pending fetch must drop the request at once.
        @(negedge clk);
        instr     = 32'h0;
        mem_ready = 1'b0;
        #2;
        check_int("prereset_mem_req", int'(mem_req), 1);
        rst_n = 1'b0;
        #1;
        check_int("async_reset_mem_req", int'(mem_req), 0);
        check_ctl("async_reset_all", 0, dut_ctl, ctl_t'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
